// File: rtl/pulse_arbiter_pkg.sv
// Shared types and default sizing for the pulse arbiter.
package pulse_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

  localparam int W_BITS_DEF     = 5;
  localparam int GAP_CYCLES_DEF = 2;

endpackage

// File: rtl/pulse_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, as one-hot and index.
module rr_picker
  import pulse_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PW-1:0]    idx,
  output logic             any
);

  always_comb begin
    logic [PW-1:0] cand;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter driving one shared, length-programmable pulse.
// Define PULSE_ARBITER_GAP_EN to insert GAP_CYCLES idle cycles after each completion.
module pulse_arbiter
  import pulse_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int W_BITS     = W_BITS_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    count_rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*W_BITS-1:0] width,
  output logic [N_REQ-1:0]        grant,
  output logic                    pulse,
  output logic [N_REQ-1:0]        done,
  output logic                    busy
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_param
    $error("pulse_arbiter: parameter out of legal range");
  end

`ifdef PULSE_ARBITER_GAP_EN
  localparam state_t AFTER_DONE = GAP;
  logic [3:0] gcnt, gcnt_next;
`else
  localparam state_t AFTER_DONE = IDLE;
`endif

  state_t            state, state_next;
  logic [W_BITS-1:0] cnt, cnt_next;
  logic [W_BITS-1:0] wlat, wsel;
  logic [PW-1:0]     ptr, ptr_next;
  logic [N_REQ-1:0]  grant_next, done_next;
  logic              pulse_next;
  logic [N_REQ-1:0]  pick;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;

  rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    wsel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) wsel = width[i*W_BITS +: W_BITS];
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ptr_next   = ptr;
    grant_next = grant;
    pulse_next = pulse;
    done_next  = '0;
`ifdef PULSE_ARBITER_GAP_EN
    gcnt_next  = gcnt;
`endif
    case (state)
      IDLE: begin
        if (pick_any) begin
          ptr_next = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          if (wsel != '0) begin
            grant_next = pick;
            pulse_next = 1'b1;
            cnt_next   = W_BITS'(1);
            state_next = PULSE;
          end else begin
            // zero-length request completes immediately without touching pulse
            done_next  = pick;
            state_next = AFTER_DONE;
`ifdef PULSE_ARBITER_GAP_EN
            gcnt_next  = '0;
`endif
          end
        end
      end
      PULSE: begin
        if (cnt == wlat) begin
          pulse_next = 1'b0;
          grant_next = '0;
          done_next  = grant;
          state_next = AFTER_DONE;
`ifdef PULSE_ARBITER_GAP_EN
          gcnt_next  = '0;
`endif
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      GAP: begin
`ifdef PULSE_ARBITER_GAP_EN
        if (gcnt == 4'(GAP_CYCLES - 1)) state_next = IDLE;
        else                            gcnt_next  = gcnt + 1'b1;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge count_rst) begin
    if (count_rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      grant <= '0;
      pulse <= 1'b0;
      done  <= '0;
`ifdef PULSE_ARBITER_GAP_EN
      gcnt  <= '0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ptr   <= ptr_next;
      grant <= grant_next;
      pulse <= pulse_next;
      done  <= done_next;
`ifdef PULSE_ARBITER_GAP_EN
      gcnt  <= gcnt_next;
`endif
    end
  end

  // Width is captured once at selection so the requester may change it freely afterwards.
  always_ff @(posedge clk) begin
    if (state == IDLE && pick_any) wlat <= wsel;
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/pulse_arbiter.md
PULSE_ARBITER -- requirements
Module: pulse_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter W_BITS, default 5: width of each pulse-length field.
REQ-003 Parameter GAP_CYCLES, default 2: idle cycles enforced between pulses, legal range 1..15.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 count_rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  N_REQ  per-requester pulse request, level, held until matching done.
REQ-007 width  input  N_REQ*W_BITS  per-requester pulse length in cycles; slice i = bits [i*W_BITS +: W_BITS].
REQ-008 grant  output  N_REQ  one-hot owner of current pulse, all-zero when none.
REQ-009 pulse  output  1  shared one-shot output, registered.
REQ-010 done  output  N_REQ  one-cycle completion strobe to the served requester.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, PULSE, GAP.
REQ-013 In IDLE with any req bit high, the next edge SHALL select a winner round-robin, starting from the requester after the last winner.
REQ-014 The winner's width slice SHALL be latched at selection; later width changes SHALL NOT affect the active pulse.
REQ-015 For latched width W>0, the selection edge SHALL set grant[winner], set pulse, load counter=1, and enter PULSE.
REQ-016 Pulse latency SHALL be exactly one cycle from the first req-high sample in IDLE to pulse high.
REQ-017 pulse SHALL remain high for exactly W consecutive cycles.
REQ-018 On the edge where counter==W, the block SHALL clear pulse and grant, assert done[winner] for one cycle, and enter GAP.
REQ-019 For latched W==0, the selection edge SHALL assert done[winner] for one cycle with no pulse and no grant, then enter GAP.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles, then enter IDLE; req is ignored during GAP.
REQ-021 A req deasserted during PULSE SHALL NOT abort the pulse; done is still issued.
REQ-022 The round-robin pointer SHALL advance to winner+1 (mod N_REQ) on every selection, including W==0 selections.
REQ-023 The counter SHALL be W_BITS wide; W = 2^W_BITS-1 is the maximum and SHALL NOT wrap.
REQ-024 Simultaneous requests SHALL be served one per pulse, with no requester starved for more than N_REQ-1 pulses.

Reset
REQ-025 count_rst high SHALL immediately force pulse=0, grant=0, done=0, busy=0, counter=0, pointer=0, and state IDLE.
REQ-026 Reset mid-pulse SHALL truncate the pulse with no done issued.
REQ-027 After count_rst falls, the first edge SHALL evaluate IDLE normally.

Configuration
REQ-028 Macro PULSE_ARBITER_GAP_EN defined: the GAP state exists per REQ-020.
REQ-029 Macro PULSE_ARBITER_GAP_EN undefined: PULSE and W==0 completion SHALL go directly to IDLE, allowing back-to-back pulses separated by one low cycle, and the GAP_CYCLES parameter is unused.

Structure
REQ-030 Package pulse_arbiter_pkg SHALL hold the state enum (IDLE, PULSE, GAP) and the default W_BITS and GAP_CYCLES constants.
REQ-031 Sub-module rr_picker SHALL implement a combinational round-robin one-hot select from req and the pointer.

Verification
REQ-032 Single request: req[1]=1, width[1]=3 -> pulse high 3 cycles starting one cycle later; grant=0010 during the pulse; done[1] on the falling edge cycle; busy low after a 2-cycle GAP.
REQ-033 Contention: req=1111, all widths=2 -> serve order 0,1,2,3, then 0; each pulse is 2 cycles with 2-cycle gaps.
REQ-034 Zero width: req[2]=1, width[2]=0 -> done[2] one cycle later, pulse never high, pointer advances to 3.
REQ-035 Reset mid-pulse: width=10, count_rst at pulse cycle 4 -> pulse drops asynchronously, no done, next request is served from requester 0.
REQ-036 Max width and width change: width=31 -> exactly 31 high cycles; changing width during the pulse has no effect.
REQ-037 Macro off: PULSE_ARBITER_GAP_EN undefined, req=0011, widths=1 -> pulses on cycles 1 and 3, busy drops for one cycle between them.
